mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle 16-bit processor.
- Serves the instruction-fetch port: the processor presents its program counter, and the block returns the instruction word on DIN.
- Serves the data port: the processor presents addtomem, datatomem and WriteEn, and the block returns read data on memin.
- Holds a unified synchronous RAM, a small memory-mapped I/O space (LED output register, switch input) and a test/program-load port.

Parameters:
- AW, 6, RAM address width; RAM depth is 2^AW words (must match the processor pc width).
- DW, 16, data and instruction word width.
- IO_BASE, 16'h8000, first address of the I/O space (address bit 15 set selects I/O).

Ports:
- Clock  in  1  system clock, rising-edge.
- Resetn  in  1  asynchronous active-low reset.
- pc  in  AW  instruction fetch address.
- DIN  out  DW  fetched instruction word, registered.
- addtomem  in  DW  data address.
- datatomem  in  DW  data to write.
- WriteEn  in  DW  write strobe vector; only bit 0 is meaningful, bits 15:1 are ignored.
- memin  out  DW  data read result, registered.
- ld_en  in  1  program-load write enable.
- ld_addr  in  AW  program-load address.
- ld_data  in  DW  program-load data.
- sw  in  DW  external switch inputs.
- leds  out  DW  LED output register.
- addr_err  out  1  sticky out-of-range access flag.
- wr_count  out  DW  count of accepted data writes.

Behaviour:
- Reset (Resetn low, asynchronous): DIN=0, memin=0, leds=0, addr_err=0, wr_count=0.
  - RAM contents are not cleared and are preserved across reset.
  - Reset asserted mid-access aborts that access: nothing is written, outputs are forced to reset values.
- Fetch port: DIN <= RAM[pc] every rising edge. Latency is 1 cycle and reads are continuous, with no enable.
- Data port, decoded every rising edge:
  - Write when WriteEn[0]=1; read otherwise.
  - RAM region: addtomem[15:AW]==0.
  - I/O region: addtomem >= IO_BASE.
  - Every other address is out of range.
- RAM write: RAM[addtomem[AW-1:0]] <= datatomem; wr_count increments by 1.
- RAM read: memin <= RAM[addr] with 1-cycle latency; memin holds its value until the next read.
- I/O:
  - Write to IO_BASE+0 sets leds <= datatomem; wr_count increments.
  - Read of IO_BASE+0 returns leds.
  - Read of IO_BASE+1 returns sw, registered once; no synchroniser required (sw is quasi-static).
  - Writes to IO_BASE+1 are ignored and flag an error.
- Out-of-range access or other I/O addresses:
  - Write: dropped, wr_count unchanged.
  - Read: memin <= 0.
  - In both cases addr_err <= 1; it stays set until reset.
- Load port:
  - ld_en=1 writes RAM[ld_addr] <= ld_data and takes priority over a same-cycle data RAM write.
  - The losing data write is dropped, addr_err <= 1, and wr_count is not incremented.
  - A data I/O write in the same cycle is unaffected.
- Collisions are read-before-write:
  - Fetch or data read of the address being written in the same cycle returns the old word; the new word is visible the following cycle.
- wr_count wraps from 16'hFFFF to 0 silently.
- No handshake or stall: the processor state machine provides the timing, and the block must accept one access per cycle.

Decomposition:
- Shared package mem_pkg holds:
  - IO_BASE, LED_OFS=0, SW_OFS=1.
  - Region enumeration REG_RAM/REG_IO/REG_BAD.
  - Word width constant.
- One sub-module, dpram_sync: a 2^AW x DW synchronous RAM.
  - Read port A: fetch.
  - Read/write port B: data or load, muxed in mem_responder.
  - Read-before-write on both ports.
- Address decode, the I/O registers, the error flag and the counter live in mem_responder.

Test Plan:
- Load program via ld_en: write 16'h0040 to address 0 and 16'h1234 to address 1; set pc=0 then 1 -> DIN is 16'h0040, then 16'h1234, each one cycle after pc changes.
- Data write of 16'hBEEF to address 5 with WriteEn=1, then a read of address 5 with WriteEn=0 -> memin=16'hBEEF on the cycle after the read; wr_count=1.
- Same-cycle data write of 16'h5555 to address 3 while pc=3, old word 16'h1111 -> DIN=16'h1111 that cycle and 16'h5555 on the next.
- I/O:
  - Write 16'h00A5 to 16'h8000 -> leds=16'h00A5.
  - With sw=16'h0F0F, read 16'h8001 -> memin=16'h0F0F.
  - Write to 16'h8001 -> leds unchanged and addr_err=1.
- Out-of-range write to address 16'h0100 with AW=6 -> RAM unchanged, wr_count unchanged, addr_err=1 and stays 1 until Resetn pulses low.
- Resetn pulsed low mid-run after writes -> DIN, memin, leds and wr_count go to 0 immediately; a reread of address 5 still returns 16'hBEEF.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the memory responder: I/O map and address regions.
package mem_pkg;
  localparam int          WORD_W  = 16;
  localparam logic [15:0] IO_BASE = 16'h8000;
  localparam logic [15:0] LED_OFS = 16'd0;
  localparam logic [15:0] SW_OFS  = 16'd1;

  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_BAD} region_e;
endpackage

// File: rtl/dpram_sync.sv
// 2^AW x DW synchronous RAM: port A read-only (fetch), port B read/write.
// Both ports are read-before-write; only the read registers are reset.
module dpram_sync #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_a,
  output logic [DW-1:0] qa,
  input  logic [AW-1:0] addr_b,
  input  logic          we_b,
  input  logic          re_b,
  input  logic [DW-1:0] wd_b,
  output logic [DW-1:0] qb
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= wd_b;
  end

  // qb only moves on an explicit read so the data port can hold its result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa <= '0;
      qb <= '0;
    end else begin
      qa <= mem[addr_a];
      if (re_b) qb <= mem[addr_b];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: fetch port, data port with RAM / memory-mapped I/O decode,
// program-load port, sticky address-error flag and accepted-write counter.
module mem_responder #(
  parameter int          AW      = 6,
  parameter int          DW      = mem_pkg::WORD_W,
  parameter logic [15:0] IO_BASE = mem_pkg::IO_BASE
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] DIN,
  input  logic [DW-1:0] addtomem,
  input  logic [DW-1:0] datatomem,
  input  logic [DW-1:0] WriteEn,
  output logic [DW-1:0] memin,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [DW-1:0] sw,
  output logic [DW-1:0] leds,
  output logic          addr_err,
  output logic [DW-1:0] wr_count
);
  import mem_pkg::*;

  region_e       region;
  logic          wr, led_hit, sw_hit;
  logic          ram_wr, led_wr, ram_rd, err;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wd_b, qb;
  logic          rd_ram_q;
  logic [DW-1:0] io_q;
  logic          unused_we_hi;

  assign unused_we_hi = ^WriteEn[DW-1:1];
  assign wr           = WriteEn[0];

  always_comb begin
    region = REG_BAD;
    if (addtomem[DW-1:AW] == '0) region = REG_RAM;
    else if (addtomem >= IO_BASE) region = REG_IO;
  end

  assign led_hit = (region == REG_IO) && (addtomem == IO_BASE + LED_OFS);
  assign sw_hit  = (region == REG_IO) && (addtomem == IO_BASE + SW_OFS);

  // The load port owns RAM port B when active; a competing data write loses and is flagged
  assign ram_wr = wr && (region == REG_RAM) && !ld_en;
  assign ram_rd = !wr && (region == REG_RAM) && !ld_en;
  assign led_wr = wr && led_hit;
  assign err    = (region == REG_BAD)
               || ((region == REG_IO) && !led_hit && !(sw_hit && !wr))
               || (wr && (region == REG_RAM) && ld_en);

  // Gating with Resetn keeps an access aborted by reset from reaching the array
  assign we_b   = Resetn && (ld_en || ram_wr);
  assign addr_b = ld_en ? ld_addr : addtomem[AW-1:0];
  assign wd_b   = ld_en ? ld_data : datatomem;

  dpram_sync #(.AW(AW), .DW(DW)) u_ram (
    .clk    (Clock),
    .rst_n  (Resetn),
    .addr_a (pc),
    .qa     (DIN),
    .addr_b (addr_b),
    .we_b   (we_b),
    .re_b   (ram_rd),
    .wd_b   (wd_b),
    .qb     (qb)
  );

  // Read result is either the RAM read register or the I/O read register
  assign memin = rd_ram_q ? qb : io_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_ram_q <= 1'b0;
      io_q     <= '0;
      leds     <= '0;
      addr_err <= 1'b0;
      wr_count <= '0;
    end else begin
      if (!wr) begin
        rd_ram_q <= ram_rd;
        if (led_hit)     io_q <= leds;
        else if (sw_hit) io_q <= sw;
        else             io_q <= '0;
      end
      if (led_wr) leds <= datatomem;
      if (ram_wr || led_wr) wr_count <= wr_count + 1'b1;
      if (err) addr_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: load, fetch, data RAM, I/O, errors and reset.
module tb_mem_responder;
  localparam int AW = 6;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic [AW-1:0] pc;
  logic [DW-1:0] DIN;
  logic [DW-1:0] addtomem, datatomem, WriteEn;
  logic [DW-1:0] memin;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] sw;
  logic [DW-1:0] leds;
  logic          addr_err;
  logic [DW-1:0] wr_count;

  int checks = 0;
  int errors = 0;

  mem_responder #(.AW(AW), .DW(DW), .IO_BASE(16'h8000)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .pc        (pc),
    .DIN       (DIN),
    .addtomem  (addtomem),
    .datatomem (datatomem),
    .WriteEn   (WriteEn),
    .memin     (memin),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .sw        (sw),
    .leds      (leds),
    .addr_err  (addr_err),
    .wr_count  (wr_count)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Resetn = 1'b1; pc = '0; addtomem = '0; datatomem = '0; WriteEn = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; sw = '0;
    #1 Resetn = 1'b0;
    step(); step();
    check("rst_din",      DIN,      16'h0000);
    check("rst_memin",    memin,    16'h0000);
    check("rst_leds",     leds,     16'h0000);
    check("rst_addr_err", {15'd0, addr_err}, 16'h0000);
    check("rst_wr_count", wr_count, 16'h0000);
    Resetn = 1'b1;

    // program load
    ld_en = 1'b1; ld_addr = 6'd0; ld_data = 16'h0040; step();
    ld_addr = 6'd1; ld_data = 16'h1234; step();
    ld_addr = 6'd3; ld_data = 16'h1111; step();
    ld_en = 1'b0;
    pc = 6'd0; step();
    check("fetch_pc0", DIN, 16'h0040);
    pc = 6'd1; step();
    check("fetch_pc1", DIN, 16'h1234);
    check("load_no_count", wr_count, 16'h0000);

    // data RAM write then read
    addtomem = 16'h0005; datatomem = 16'hBEEF; WriteEn = 16'h0001; step();
    check("wr5_count", wr_count, 16'h0001);
    WriteEn = 16'h0000; step();
    check("rd5_memin", memin, 16'hBEEF);

    // LED write; memin must hold the previous read
    addtomem = 16'h8000; datatomem = 16'h00A5; WriteEn = 16'h0001; step();
    check("led_val",   leds,     16'h00A5);
    check("led_count", wr_count, 16'h0002);
    check("memin_hold", memin,   16'hBEEF);

    // read-before-write collision on the fetch port
    pc = 6'd3; addtomem = 16'h0003; datatomem = 16'h5555; WriteEn = 16'h0001; step();
    check("coll_old", DIN, 16'h1111);
    check("coll_count", wr_count, 16'h0003);
    WriteEn = 16'h0000; step();
    check("coll_new", DIN, 16'h5555);
    check("coll_rd", memin, 16'h5555);

    // I/O reads
    sw = 16'h0F0F; addtomem = 16'h8001; step();
    check("sw_rd", memin, 16'h0F0F);
    addtomem = 16'h8000; step();
    check("led_rd", memin, 16'h00A5);
    check("err_clear", {15'd0, addr_err}, 16'h0000);

    // write to switch register: ignored, flagged
    addtomem = 16'h8001; datatomem = 16'hFFFF; WriteEn = 16'h0001; step();
    check("swwr_leds",  leds,     16'h00A5);
    check("swwr_err",   {15'd0, addr_err}, 16'h0001);
    check("swwr_count", wr_count, 16'h0003);

    // asynchronous reset mid-cycle, with a write pending that must not land
    addtomem = 16'h0005; datatomem = 16'h0000;
    #3 Resetn = 1'b0;
    #1;
    check("arst_din",   DIN,      16'h0000);
    check("arst_memin", memin,    16'h0000);
    check("arst_leds",  leds,     16'h0000);
    check("arst_err",   {15'd0, addr_err}, 16'h0000);
    check("arst_count", wr_count, 16'h0000);
    step();
    Resetn = 1'b1; WriteEn = 16'h0000; step();
    check("reread5", memin, 16'hBEEF);
    check("post_rst_count", wr_count, 16'h0000);

    // out-of-range write aliasing address 0 must not touch RAM
    pc = 6'd0; addtomem = 16'h0100; datatomem = 16'hDEAD; WriteEn = 16'h0001; step();
    check("oor_err",   {15'd0, addr_err}, 16'h0001);
    check("oor_count", wr_count, 16'h0000);
    addtomem = 16'h0000; WriteEn = 16'h0000; step();
    check("oor_ram_rd",  memin, 16'h0040);
    check("oor_ram_din", DIN,   16'h0040);
    addtomem = 16'h4000; step();
    check("oor_rd_zero", memin, 16'h0000);

    // load wins over same-cycle data RAM write
    ld_en = 1'b1; ld_addr = 6'd7; ld_data = 16'h7777;
    addtomem = 16'h0007; datatomem = 16'h8888; WriteEn = 16'h0001; step();
    check("ldprio_count", wr_count, 16'h0000);
    // load alongside an LED write: I/O write still accepted
    ld_addr = 6'd9; ld_data = 16'h0909; addtomem = 16'h8000; datatomem = 16'h003C; step();
    check("ldio_leds",  leds,     16'h003C);
    check("ldio_count", wr_count, 16'h0001);
    ld_en = 1'b0; WriteEn = 16'h0000; pc = 6'd7; addtomem = 16'h0007; step();
    check("ldprio_din",   DIN,   16'h7777);
    check("ldprio_memin", memin, 16'h7777);
    step(); step();
    check("err_sticky", {15'd0, addr_err}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
